// File: rtl/picorv32_mmio_pkg.sv
// Shared constants, decode targets and FSM state types for the picorv32 MMIO router.
package picorv32_mmio_pkg;

  localparam int unsigned DEF_MEM_BYTES  = 65536;
  localparam int unsigned DEF_CON_DEPTH  = 4;
  localparam logic [31:0] DEF_CON_ADDR   = 32'h1000_0000;
  localparam logic [31:0] DEF_PASS_ADDR  = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] OOB_RDATA      = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {MEM, CON, PASS, OOB} tgt_e;

  typedef enum logic [2:0] {W_IDLE, W_FWD, W_MWAIT, W_LOCAL, W_RESP} wstate_e;

  typedef enum logic [1:0] {R_IDLE, R_FWD, R_MWAIT, R_RESP} rstate_e;

  // Exact full-width address decode.
  function automatic tgt_e decode(input logic [31:0] addr, input logic [31:0] mem_bytes,
                                  input logic [31:0] con_addr, input logic [31:0] pass_addr);
    if (addr < mem_bytes) return MEM;
    if (addr == con_addr) return CON;
    if (addr == pass_addr) return PASS;
    return OOB;
  endfunction

endpackage

// File: rtl/mmio_con_fifo.sv
// First-word fall-through byte FIFO for the console; push while full is taken only alongside a pop.
module mmio_con_fifo #(
  parameter int unsigned CON_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(CON_DEPTH):0] count
);

  localparam int unsigned AW = $clog2(CON_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [CON_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(CON_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < CON_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == CW'(CON_DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/picorv32_mmio_router.sv
// AXI4-Lite router: forwards the memory window downstream and serves console/pass MMIO locally.
module picorv32_mmio_router
  import picorv32_mmio_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = DEF_MEM_BYTES,
  parameter logic [31:0] CON_ADDR   = DEF_CON_ADDR,
  parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_MAGIC = DEF_PASS_MAGIC,
  parameter int unsigned CON_DEPTH  = DEF_CON_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        tests_passed,
  output logic        oob_err
);

  wstate_e     w_state, w_state_n;
  rstate_e     r_state, r_state_n;
  logic        run;
  logic        aw_have, w_have, m_aw_done, m_w_done;
  logic [31:0] awaddr_q, wdata_q, araddr_q, rdata_q;
  logic [2:0]  awprot_q, arprot_q;
  logic [3:0]  wstrb_q;
  tgt_e        w_tgt, new_wtgt, r_tgt;
  logic        tests_passed_q, oob_q;

  logic        aw_take, w_take, ar_take, m_aw_hs, m_w_hs;
  logic [31:0] eff_awaddr;
  logic        con_push, con_pop, con_full, con_empty;
  logic        set_pass, w_set_oob, r_set_oob;
  logic [$clog2(CON_DEPTH):0] con_count;
  logic        unused_con_count;

  assign aw_take    = s_axi_awvalid && s_axi_awready;
  assign w_take     = s_axi_wvalid && s_axi_wready;
  assign ar_take    = s_axi_arvalid && s_axi_arready;
  assign m_aw_hs    = m_axi_awvalid && m_axi_awready;
  assign m_w_hs     = m_axi_wvalid && m_axi_wready;
  assign eff_awaddr = aw_have ? awaddr_q : s_axi_awaddr;
  assign new_wtgt   = decode(eff_awaddr, 32'(MEM_BYTES), CON_ADDR, PASS_ADDR);
  assign r_tgt      = decode(s_axi_araddr, 32'(MEM_BYTES), CON_ADDR, PASS_ADDR);
  assign con_pop    = con_valid && con_ready;

  mmio_con_fifo #(.CON_DEPTH(CON_DEPTH)) u_con_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (con_push),
    .din    (wdata_q[7:0]),
    .pop    (con_pop),
    .dout   (con_data),
    .full   (con_full),
    .empty  (con_empty),
    .count  (con_count)
  );
  assign unused_con_count = ^con_count;

  // State registers; run keeps every ready low until the first edge after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      run     <= 1'b0;
    end else begin
      w_state <= w_state_n;
      r_state <= r_state_n;
      run     <= 1'b1;
    end
  end

  // Write next-state and local side effects.
  always_comb begin
    w_state_n = w_state;
    con_push  = 1'b0;
    set_pass  = 1'b0;
    w_set_oob = 1'b0;
    case (w_state)
      W_IDLE:  if ((aw_have || aw_take) && (w_have || w_take))
                 w_state_n = (new_wtgt == MEM) ? W_FWD : W_LOCAL;
      W_FWD:   if ((m_aw_done || m_aw_hs) && (m_w_done || m_w_hs)) w_state_n = W_MWAIT;
      W_MWAIT: if (m_axi_bvalid) w_state_n = W_RESP;
      W_LOCAL: begin
        case (w_tgt)
          CON: if (!con_full || con_pop) begin
            con_push  = 1'b1;
            w_state_n = W_RESP;
          end
          PASS: begin
            set_pass  = (wdata_q == PASS_MAGIC);
            w_state_n = W_RESP;
          end
          default: begin
            w_set_oob = 1'b1;
            w_state_n = W_RESP;
          end
        endcase
      end
      W_RESP:  if (s_axi_bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read next-state.
  always_comb begin
    r_state_n = r_state;
    r_set_oob = 1'b0;
    case (r_state)
      R_IDLE: if (ar_take) begin
        r_state_n = (r_tgt == MEM) ? R_FWD : R_RESP;
        r_set_oob = (r_tgt == OOB);
      end
      R_FWD:   if (m_axi_arready) r_state_n = R_MWAIT;
      R_MWAIT: if (m_axi_rvalid) r_state_n = R_RESP;
      R_RESP:  if (s_axi_rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Transaction payload, downstream handshake tracking and sticky flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_have        <= 1'b0;
      w_have         <= 1'b0;
      m_aw_done      <= 1'b0;
      m_w_done       <= 1'b0;
      awaddr_q       <= '0;
      awprot_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      w_tgt          <= MEM;
      araddr_q       <= '0;
      arprot_q       <= '0;
      rdata_q        <= '0;
      tests_passed_q <= 1'b0;
      oob_q          <= 1'b0;
    end else begin
      if (aw_take) begin
        awaddr_q <= s_axi_awaddr;
        awprot_q <= s_axi_awprot;
        aw_have  <= 1'b1;
      end
      if (w_take) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
        w_have  <= 1'b1;
      end
      if (w_state == W_IDLE && w_state_n != W_IDLE) w_tgt <= new_wtgt;
      if (w_state == W_FWD) begin
        if (m_aw_hs) m_aw_done <= 1'b1;
        if (m_w_hs) m_w_done <= 1'b1;
        if (w_state_n != W_FWD) begin
          m_aw_done <= 1'b0;
          m_w_done  <= 1'b0;
        end
      end
      if (w_state == W_RESP && s_axi_bready) begin
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end
      if (ar_take) begin
        araddr_q <= s_axi_araddr;
        arprot_q <= s_axi_arprot;
        case (r_tgt)
          CON:     rdata_q <= {30'b0, con_full, con_empty};
          PASS:    rdata_q <= {31'b0, tests_passed_q};
          OOB:     rdata_q <= OOB_RDATA;
          default: rdata_q <= rdata_q;
        endcase
      end
      if (r_state == R_MWAIT && m_axi_rvalid) rdata_q <= m_axi_rdata;
      tests_passed_q <= tests_passed_q | set_pass;
      oob_q          <= oob_q | w_set_oob | r_set_oob;
    end
  end

  assign s_axi_awready = run && (w_state == W_IDLE) && !aw_have;
  assign s_axi_wready  = run && (w_state == W_IDLE) && !w_have;
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_arready = run && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_RESP);
  assign s_axi_rdata   = rdata_q;

  assign m_axi_awvalid = (w_state == W_FWD) && !m_aw_done;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = awprot_q;
  assign m_axi_wvalid  = (w_state == W_FWD) && !m_w_done;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = (w_state == W_MWAIT);
  assign m_axi_arvalid = (r_state == R_FWD);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = arprot_q;
  assign m_axi_rready  = (r_state == R_MWAIT);

  assign con_valid     = !con_empty;
  assign tests_passed  = tests_passed_q;
  assign oob_err       = oob_q;

endmodule

// File: tb/tb_picorv32_mmio_router.sv
// Directed bench for picorv32_mmio_router with a zero-wait AXI4-Lite memory model.
module tb_picorv32_mmio_router;

  localparam logic [31:0] CON_A  = 32'h1000_0000;
  localparam logic [31:0] PASS_A = 32'h2000_0000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic        con_valid, con_ready, tests_passed, oob_err;
  logic [7:0]  con_data;

  picorv32_mmio_router dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .tests_passed(tests_passed), .oob_err(oob_err)
  );

  // Memory model: always-ready, word array indexed by addr[9:2]; hold_b stalls the B response.
  logic [31:0] mem [256];
  logic        hold_b, got_aw, got_w;
  logic [31:0] pend_addr, pend_data, mon_awaddr, mon_wdata;
  logic [3:0]  pend_strb, mon_wstrb;
  logic [2:0]  mon_awprot;
  int          mon_aw_cnt = 0, mon_ar_cnt = 0;

  assign m_axi_awready = 1'b1;
  assign m_axi_wready  = 1'b1;
  assign m_axi_arready = 1'b1;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      got_aw <= 1'b0; got_w <= 1'b0; m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
      m_axi_rdata <= '0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        got_aw <= 1'b1; pend_addr <= m_axi_awaddr;
        mon_awaddr <= m_axi_awaddr; mon_awprot <= m_axi_awprot; mon_aw_cnt <= mon_aw_cnt + 1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        got_w <= 1'b1; pend_data <= m_axi_wdata; pend_strb <= m_axi_wstrb;
        mon_wdata <= m_axi_wdata; mon_wstrb <= m_axi_wstrb;
      end
      if (got_aw && got_w && !m_axi_bvalid && !hold_b) begin
        for (int i = 0; i < 4; i++)
          if (pend_strb[i]) mem[pend_addr[9:2]][8*i +: 8] <= pend_data[8*i +: 8];
        m_axi_bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end else if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1; m_axi_rdata <= mem[m_axi_araddr[9:2]]; mon_ar_cnt <= mon_ar_cnt + 1;
      end else if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  logic [7:0] con_q[$];
  always @(posedge clk) if (resetn && con_valid && con_ready) con_q.push_back(con_data);

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // order: 0 = AW and W together, 1 = W first, 2 = AW first.
  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order);
    logic aw_done, w_done, aw_now, w_now;
    int g;
    @(negedge clk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s; s_axi_awprot = 3'b010;
    aw_done = 1'b0; w_done = 1'b0; g = 0;
    if (order != 1) s_axi_awvalid = 1'b1;
    if (order != 2) s_axi_wvalid = 1'b1;
    while (!(aw_done && w_done) && g < 50) begin
      aw_now = s_axi_awvalid && s_axi_awready;
      w_now  = s_axi_wvalid && s_axi_wready;
      @(negedge clk); g++;
      if (aw_now) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_now) begin s_axi_wvalid = 1'b0; w_done = 1'b1; end
      if (!aw_done && !s_axi_awvalid && w_done) s_axi_awvalid = 1'b1;
      if (!w_done && !s_axi_wvalid && aw_done) s_axi_wvalid = 1'b1;
    end
    if (!(aw_done && w_done)) check("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  // Latency counted in cycles from the final AW/W handshake cycle; -1 when the budget runs out.
  task automatic wait_b(input int budget, output int lat);
    lat = 1;
    while (!s_axi_bvalid && lat < budget) begin @(negedge clk); lat++; end
    if (!s_axi_bvalid) lat = -1;
    else begin s_axi_bready = 1'b1; @(negedge clk); s_axi_bready = 1'b0; end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    int g = 0;
    @(negedge clk);
    s_axi_araddr = a; s_axi_arprot = 3'b001; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    lat = 1;
    while (!s_axi_rvalid && lat < 50) begin @(negedge clk); lat++; end
    d = s_axi_rdata;
    if (!s_axi_rvalid) lat = -1;
    s_axi_rready = 1'b1; @(negedge clk); s_axi_rready = 1'b0;
  endtask

  function automatic logic [31:0] ctl_vec();
    return {19'b0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
            m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
            con_valid, tests_passed, oob_err};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, aw_before, ar_before;
    resetn = 1'b0; hold_b = 1'b0; con_ready = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_wvalid = 0; s_axi_wdata = 0;
    s_axi_wstrb = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arprot = 0;
    s_axi_rready = 0;
    repeat (3) @(negedge clk);
    check("reset_ctl", ctl_vec(), 32'h0);
    check("reset_data", s_axi_rdata | m_axi_awaddr | m_axi_wdata | m_axi_araddr | {24'b0, con_data}, 32'h0);
    resetn = 1'b1;
    @(negedge clk); @(negedge clk);
    check("idle_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);

    // MEM write then read back through the memory model.
    send_aw_w(32'h100, 32'hA5A5_1234, 4'b0011, 0);
    wait_b(20, lat);
    check("mem_wr_b", 32'(lat != -1), 32'd1);
    check("mem_wr_awaddr", mon_awaddr, 32'h100);
    check("mem_wr_wdata", mon_wdata, 32'hA5A5_1234);
    check("mem_wr_strb_prot", {25'b0, mon_awprot, mon_wstrb}, {25'b0, 3'b010, 4'b0011});
    do_read(32'h100, rd, lat);
    check("mem_rd_data", rd, 32'h0000_1234);
    check("mem_rd_lat", 32'(lat), 32'd3);
    check("mem_oob_clear", 32'(oob_err), 32'd0);

    // Console write with sink ready.
    con_ready = 1'b1;
    send_aw_w(CON_A, 32'hFFFF_FF48, 4'b0001, 0);
    wait_b(20, lat);
    check("con_b_lat", 32'(lat), 32'd2);
    repeat (2) @(negedge clk);
    check("con_q_size", 32'(con_q.size()), 32'd1);
    if (con_q.size() == 1) check("con_byte", 32'(con_q[0]), 32'h48);
    con_q.delete();

    // Fill the FIFO with the sink stalled; the fifth write must stall its response.
    con_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_aw_w(CON_A, 32'(8'h61 + i), 4'b1111, 0);
      wait_b(20, lat);
      check("fill_b_lat", 32'(lat), 32'd2);
    end
    send_aw_w(CON_A, 32'h65, 4'b1111, 0);
    wait_b(8, lat);
    check("full_b_withheld", 32'(lat), 32'hFFFF_FFFF);
    do_read(CON_A, rd, lat);
    check("con_stat_full", rd, 32'h2);
    check("local_rd_lat", 32'(lat), 32'd1);
    @(negedge clk); con_ready = 1'b1;
    wait_b(20, lat);
    check("full_b_released", 32'(lat != -1), 32'd1);
    repeat (8) @(negedge clk);
    check("drain_size", 32'(con_q.size()), 32'd5);
    if (con_q.size() == 5)
      check("drain_order", {con_q[0], con_q[1], con_q[2], con_q[3]}, 32'h6162_6364);
    if (con_q.size() == 5) check("drain_last", 32'(con_q[4]), 32'h65);
    do_read(CON_A, rd, lat);
    check("con_stat_empty", rd, 32'h1);
    con_q.delete();

    // Pass flag: near-miss value ignored, magic sets it.
    send_aw_w(PASS_A, 32'd123456788, 4'b1111, 0);
    wait_b(20, lat);
    check("pass_bad_lat", 32'(lat), 32'd2);
    check("pass_bad", 32'(tests_passed), 32'd0);
    send_aw_w(PASS_A, 32'd123456789, 4'b1111, 0);
    wait_b(20, lat);
    check("pass_good", 32'(tests_passed), 32'd1);
    do_read(PASS_A, rd, lat);
    check("pass_rd", rd, 32'h1);

    // Window edges and unmapped accesses.
    ar_before = mon_ar_cnt;
    do_read(32'h0000_FFFC, rd, lat);
    check("mem_top_fwd", 32'(mon_ar_cnt - ar_before), 32'd1);
    check("mem_top_oob", 32'(oob_err), 32'd0);
    do_read(32'h0001_0000, rd, lat);
    check("edge_oob_rd", rd, 32'hDEAD_BEEF);
    check("edge_oob_flag", 32'(oob_err), 32'd1);
    do_read(32'h0002_0000, rd, lat);
    check("oob_rd", rd, 32'hDEAD_BEEF);
    check("oob_rd_lat", 32'(lat), 32'd1);
    aw_before = mon_aw_cnt;
    send_aw_w(32'h3000_0000, 32'h1234_5678, 4'b1111, 0);
    wait_b(20, lat);
    check("oob_wr_lat", 32'(lat), 32'd2);
    check("oob_wr_no_fwd", 32'(mon_aw_cnt - aw_before), 32'd0);

    // Ordering variants.
    send_aw_w(32'h200, 32'h1122_3344, 4'b1111, 1);
    wait_b(20, lat);
    check("w_first_addr", mon_awaddr, 32'h200);
    check("w_first_data", mon_wdata, 32'h1122_3344);
    send_aw_w(CON_A, 32'h5A, 4'b0001, 2);
    wait_b(20, lat);
    check("aw_first_lat", 32'(lat), 32'd2);
    repeat (2) @(negedge clk);
    check("aw_first_byte", con_q.size() == 1 ? 32'(con_q[0]) : 32'hFFFF_FFFF, 32'h5A);

    // Reset while waiting for the downstream write response.
    hold_b = 1'b1;
    send_aw_w(32'h300, 32'h0BAD_0BAD, 4'b1111, 0);
    repeat (3) @(negedge clk);
    check("mwait_bready", 32'(m_axi_bready), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_ctl", ctl_vec(), 32'h0);
    check("midrst_data", s_axi_rdata | m_axi_awaddr | m_axi_wdata | {24'b0, con_data}, 32'h0);
    @(negedge clk);
    resetn = 1'b1; hold_b = 1'b0;
    @(negedge clk);
    send_aw_w(32'h104, 32'hCAFE_F00D, 4'b1111, 0);
    wait_b(20, lat);
    check("post_rst_b", 32'(lat != -1), 32'd1);
    do_read(32'h104, rd, lat);
    check("post_rst_rd", rd, 32'hCAFE_F00D);
    check("post_rst_flags", {30'b0, tests_passed, oob_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/picorv32_mmio_router.md
# picorv32_mmio_router

Synthesizable AXI4-Lite address router between the `picorv32_axi` master port and the 64 KiB AXI4-Lite program memory. Forwards in-range accesses to memory and services two MMIO words locally: a console byte output with a small FIFO, and a pass-flag register. Flags out-of-range accesses instead of stopping simulation, so the same system can run on FPGA.

## Interface
Parameters:
- MEM_BYTES, 65536: memory window is `[0, MEM_BYTES)`, routed downstream.
- CON_ADDR, 32'h1000_0000: console data word address.
- PASS_ADDR, 32'h2000_0000: pass-flag word address.
- PASS_MAGIC, 123456789: write value that sets `tests_passed`.
- CON_DEPTH, 4: console FIFO depth, a power of two ≥ 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_axi_aw{valid,ready,addr[31:0],prot[2:0]}, s_axi_w{valid,ready,data[31:0],strb[3:0]}, s_axi_b{valid,ready}, s_axi_ar{valid,ready,addr[31:0],prot[2:0]}, s_axi_r{valid,ready,data[31:0]}  mixed  per name  upstream slave port from CPU
- m_axi_* (same signal set, directions mirrored)  mixed  per name  downstream master port to memory
- con_valid  out  1  console byte available
- con_ready  in  1  console sink accepts byte
- con_data  out  8  console byte
- tests_passed  out  1  sticky; set by a PASS_MAGIC write
- oob_err  out  1  sticky; set by any unmapped access

## Operation
- Address decode is exact, on the full 32 bits:
  - MEM if `addr < MEM_BYTES`
  - CON if `addr == CON_ADDR`
  - PASS if `addr == PASS_ADDR`
  - otherwise OOB
- Write and read FSMs are independent; each has at most one transaction outstanding.
- Write FSM states: W_IDLE, W_FWD, W_MWAIT, W_LOCAL, W_RESP.
  - W_IDLE: AW and W are latched independently. `s_axi_awready` is high while no AW is latched; `s_axi_wready` is high while no W is latched. Once both are latched, decode:
    - MEM → W_FWD
    - CON, PASS or OOB → W_LOCAL
  - W_FWD: drives `m_axi_awvalid` and `m_axi_wvalid` with the latched addr, prot, data and strb. Each valid drops independently on its own handshake. When both have handshaked → W_MWAIT.
  - W_MWAIT: `m_axi_bready`=1. On `m_axi_bvalid` → W_RESP.
  - W_LOCAL, by target:
    - CON: push `wdata[7:0]` (strb ignored). Stay in W_LOCAL while the FIFO is full.
    - PASS: `tests_passed` ← 1 if `wdata == PASS_MAGIC`. Other values have no effect.
    - OOB: `oob_err` ← 1.
    - Then → W_RESP.
  - W_RESP: `s_axi_bvalid`=1 until `s_axi_bready`, then → W_IDLE.
- Read FSM states: R_IDLE, R_FWD, R_MWAIT, R_RESP.
  - R_IDLE: `s_axi_arready`=1. On handshake, latch the address and decode:
    - MEM → R_FWD
    - otherwise → R_RESP, with local rdata:
      - CON: `{30'b0, fifo_full, fifo_empty}`
      - PASS: `{31'b0, tests_passed}`
      - OOB: 32'hDEAD_BEEF, and `oob_err` ← 1
  - R_FWD: `m_axi_arvalid` until handshake → R_MWAIT.
  - R_MWAIT: `m_axi_rready`=1. On `m_axi_rvalid`, capture rdata → R_RESP.
  - R_RESP: `s_axi_rvalid`=1 until `s_axi_rready`, then → R_IDLE.
- Console FIFO: first-word fall-through. `con_valid` = not empty. Pop on `con_valid && con_ready`. A push and a pop in the same cycle are both allowed when full; occupancy is unchanged.

## Timing
- Reset values: all `*valid`, `*ready` and `con_valid` = 0; `tests_passed`=0; `oob_err`=0; FIFO empty; FSMs idle. Data outputs are 0.
- A reset assertion mid-transaction aborts the transaction immediately. No response is generated and downstream valids drop asynchronously.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- MEM read: AR handshake at cycle 0; `m_axi_arvalid` at cycle 1. With zero-wait memory, `s_axi_rvalid` comes 1 cycle after the `m_axi_rvalid` handshake.
- Local read: `s_axi_rvalid` at cycle 1 after the AR handshake.
- Local write: `s_axi_bvalid` 2 cycles after the cycle in which both AW and W are latched, when the FIFO is not full.
- AW and W may arrive in either order or in the same cycle. The second one is accepted at any later cycle.
- Upstream valid or payload changes while waiting are an AXI protocol violation; the router does not check for them.

## Structure
- Shared package `picorv32_mmio_pkg`:
  - default address and magic constants
  - decode enum {MEM, CON, PASS, OOB}
  - write and read state enums
- One sub-module, `mmio_con_fifo` (parameter CON_DEPTH): synchronous FWFT FIFO with async reset, exposing push, pop, full, empty and count.

## Test plan
- MEM write to 0x100, data 0xA5A5_1234, strb 4'b0011, then read 0x100 → downstream sees an identical AW/W; read returns memory's data; `oob_err`=0.
- Write 0x48 to CON_ADDR with `con_ready`=1 → `con_valid` with `con_data`=8'h48, then `s_axi_bvalid`.
- `con_ready`=0, then CON_DEPTH+1 writes → the last write's bvalid is withheld. Raise `con_ready` → bytes are emitted in order and the last bvalid follows.
- Write 123456788, then 123456789, to PASS_ADDR → `tests_passed` stays 0, then goes 1; reading PASS_ADDR returns 1.
- Read from 0x0002_0000 → rdata 0xDEAD_BEEF and `oob_err`=1. Write to 0x3000_0000 → bvalid returned, no downstream activity.
- W before AW, AW/W in the same cycle, and `resetn` pulsed during W_MWAIT → correct routing in the first two cases; after reset, all outputs are at their reset values and the next transaction completes normally.
